// File: rtl/sram_pkg.sv
// Shared definitions for the external asynchronous SRAM bridge.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ACK
  } state_e;

  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned INIT_CYCLES_DEF = 16;
  localparam int unsigned WCNT_W          = 4;

endpackage

// File: rtl/sram_init_timer.sv
// Post-reset down-counter: ready_o rises INIT_CYCLES clocks after reset release.
// ready_nxt_o is the value ready_o takes on the next edge, so a consumer FSM
// can change state on the same edge that ready_o rises.
module sram_init_timer #(
  parameter int unsigned INIT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic ready_o,
  output logic ready_nxt_o
);

  localparam int unsigned CNT_W = ($clog2(INIT_CYCLES + 1) < 1) ? 1 : $clog2(INIT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;

  // Count down to zero and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign ready_nxt_o = (cnt_d == '0);
  assign ready_o     = ready_q;

  // Counter and ready flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= CNT_W'(INIT_CYCLES);
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_nxt_o;
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// Terminates the sdram_* bus on a 16-bit asynchronous SRAM with
// programmable wait states. All SRAM pin outputs come straight from flops.
module sram_bridge
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              sdram_stb,
  input  logic              sdram_we,
  input  logic [1:0]        sdram_sel,
  input  logic [21:1]       sdram_adr,
  input  logic [15:0]       sdram_out,
  output logic [15:0]       sdram_dat,
  output logic              sdram_ack,
  output logic              sdram_ready,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dat_q, dat_d;
  logic                ack_q, ack_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_in_q;
  logic                init_ready, init_ready_nxt;

  sram_init_timer #(
    .INIT_CYCLES(INIT_CYCLES)
  ) u_init_timer (
    .clk_i      (clk_p),
    .rst_ni     (rst_n),
    .ready_o    (init_ready),
    .ready_nxt_o(init_ready_nxt)
  );

  // Address bits above the SRAM width are deliberately dropped (aliasing).
  if (ADDR_W < 21) begin : g_alias
    logic unused_adr_hi;
    assign unused_adr_hi = ^sdram_adr[21:ADDR_W+1];
  end

  assign sram_dq     = dq_oe_q ? wdata_q : 'z;
  assign sdram_dat   = dat_q;
  assign sdram_ack   = ack_q & sdram_stb;
  assign sdram_ready = init_ready;
  assign sram_addr   = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;

  // Next-state and next pin values; pins are computed for the state being
  // entered so that every SRAM control is registered.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    ack_d   = ack_q;
    wcnt_d  = wcnt_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_ready_nxt) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (sdram_stb && init_ready) begin
          wr_d    = sdram_we;
          sel_d   = sdram_sel;
          wdata_d = sdram_out;
          addr_d  = sdram_adr[ADDR_W:1];
          state_d = ST_SETUP;
          ce_n_d  = 1'b0;
          ub_n_d  = ~sdram_sel[1];
          lb_n_d  = ~sdram_sel[0];
          oe_n_d  = sdram_we;
          dq_oe_d = sdram_we;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
        ce_n_d  = 1'b0;
        ub_n_d  = ~sel_q[1];
        lb_n_d  = ~sel_q[0];
        oe_n_d  = wr_q;
        we_n_d  = ~wr_q;
        dq_oe_d = wr_q;
      end
      ST_ACCESS: begin
        if (wcnt_q == '0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (!wr_q) begin
            dat_d = dq_in_q;
          end else begin
            // Write hold cycle: we_n rises while ce_n, lanes and dq stay put.
            ce_n_d  = 1'b0;
            ub_n_d  = ~sel_q[1];
            lb_n_d  = ~sel_q[0];
            dq_oe_d = 1'b1;
          end
        end else begin
          wcnt_d  = wcnt_q - WCNT_W'(1);
          ce_n_d  = 1'b0;
          ub_n_d  = ~sel_q[1];
          lb_n_d  = ~sel_q[0];
          oe_n_d  = wr_q;
          we_n_d  = ~wr_q;
          dq_oe_d = wr_q;
        end
      end
      ST_ACK: begin
        if (!sdram_stb) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, latched request and registered SRAM pins.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      wcnt_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      dq_in_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      wcnt_q  <= wcnt_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
      dq_in_q <= sram_dq;
    end
  end

endmodule
